// File: rtl/instruction_fetch.sv
// Instruction fetch stage.
// Reads one 32-bit word per cycle from a synchronous instruction memory
// that returns data one cycle after the request. The stage also handles
// stall, redirect (branch/jump) and an out-of-range fetch fault.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to halt with a fault
// when a redirect target is not word aligned. If the macro is not defined,
// the low two target bits are ignored.
module instruction_fetch #(
  parameter int          NumEntries = 31,
  parameter logic [31:0] ResetPc    = 32'h0000_0000
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  stall_i,
  input  logic                                  redirect_i,
  input  logic [31:0]                           redirect_pc_i,
  output logic                                  imem_rd_valid_o,
  output logic [$clog2(NumEntries)-1:0]         imem_rd_addr_o,
  input  logic [31:0]                           imem_rd_data_i,
  output logic                                  if_valid_o,
  output logic [31:0]                           if_pc_o,
  output logic [31:0]                           if_instr_o,
  output logic                                  fetch_fault_o
);

  localparam int AddrWidth = $clog2(NumEntries);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q;
  logic [31:0]            req_pc_q;
  logic                   inflight_q;
  logic [AddrWidth-1:0]   word_idx;
  logic                   in_range;
  logic                   misalign;

  assign word_idx = pc_q[AddrWidth+1:2];

  // An address is valid only if its word index is inside the memory and
  // no upper address bits are set. This catches PCs that would alias
  // back into the memory if only the index bits were used.
  assign in_range = ({1'b0, word_idx} < (AddrWidth+1)'(NumEntries))
                  && (pc_q[31:AddrWidth+2] == '0);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  logic unused_redirect_low_bits;
  assign misalign                 = 1'b0;
  assign unused_redirect_low_bits = ^redirect_pc_i[1:0];
`endif

  // State register for the RUN/HALT controller.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a redirect always wins. Otherwise, running off the
  // end of the memory halts fetch.
  always_comb begin
    // NOTE: default first so that no path through this block leaves
    // state_d unassigned and infers a latch.
    state_d = state_q;
    if (redirect_i) begin
      state_d = misalign ? HALT : RUN;
    end else if ((state_q == RUN) && !in_range) begin
      state_d = HALT;
    end
  end

  // Controller outputs: the request strobe and the fault flag.
  always_comb begin
    imem_rd_valid_o = (state_q == RUN) && !stall_i && !redirect_i
                      && !reset_i && in_range;
    fetch_fault_o   = (state_q == HALT);
  end

  assign imem_rd_addr_o = word_idx;

  // Fetch datapath: the next-PC register, the PC of the request in flight,
  // and a flag that says the memory output holds a real instruction.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= ResetPc;
      req_pc_q   <= ResetPc;
      inflight_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else if (imem_rd_valid_o) begin
      pc_q       <= pc_q + 32'd4;
      req_pc_q   <= pc_q;
      inflight_q <= 1'b1;
    end else if (!stall_i) begin
      // Decode took the current instruction and no new one is coming.
      inflight_q <= 1'b0;
    end
  end

  // The memory keeps its read data while no request is made, so the
  // instruction stays stable during a stall without any extra register.
  assign if_instr_o = imem_rd_data_i;
  assign if_pc_o    = req_pc_q;
  assign if_valid_o = inflight_q && !redirect_i && !stall_i;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. It uses a behavioural
// synchronous memory that holds its data when there is no read, and
// every expected value is worked out by hand.
module tb_instruction_fetch;

  localparam int NumEntries = 31;
  localparam int AddrWidth  = $clog2(NumEntries);

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic                 stall_i;
  logic                 redirect_i;
  logic [31:0]          redirect_pc_i;
  logic                 imem_rd_valid_o;
  logic [AddrWidth-1:0] imem_rd_addr_o;
  logic [31:0]          imem_rd_data_i;
  logic                 if_valid_o;
  logic [31:0]          if_pc_o;
  logic [31:0]          if_instr_o;
  logic                 fetch_fault_o;

  logic [31:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch #(.NumEntries(NumEntries), .ResetPc(32'h0)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_rd_valid_o(imem_rd_valid_o),
    .imem_rd_addr_o (imem_rd_addr_o),
    .imem_rd_data_i (imem_rd_data_i),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_instr_o     (if_instr_o),
    .fetch_fault_o  (fetch_fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read instruction memory with one cycle of latency.
  always @(posedge clk_i) begin
    if (imem_rd_valid_o) imem_rd_data_i <= mem[imem_rd_addr_o];
  end

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; the caller then drives the
  // inputs and waits #1 before it samples anything.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = word(i);
    imem_rd_data_i = '0;
    reset_i       = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    #1;
    check("rst_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    step();
    step();
    check("rst_if_valid", 32'(if_valid_o), 32'd0);
    check("rst_fault", 32'(fetch_fault_o), 32'd0);

    // Sequential fetch from word 0. If_valid lags the request by one cycle.
    reset_i = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("seq_rd_valid%0d", c), 32'(imem_rd_valid_o), 32'd1);
      check($sformatf("seq_addr%0d", c), 32'(imem_rd_addr_o), 32'(c));
      check($sformatf("seq_if_valid%0d", c), 32'(if_valid_o), (c == 0) ? 32'd0 : 32'd1);
      if (c > 0) begin
        check($sformatf("seq_if_pc%0d", c), if_pc_o, 32'(4 * (c - 1)));
        check($sformatf("seq_instr%0d", c), if_instr_o, word(c - 1));
      end
      step();
    end

    // Reset in the middle of a run, then the stall test at pc_q = 0x8.
    reset_i = 1'b1;
    #1;
    check("rst2_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    step();
    reset_i = 1'b0;
    #1;
    check("rst2_if_valid", 32'(if_valid_o), 32'd0);
    check("rst2_addr", 32'(imem_rd_addr_o), 32'd0);
    step();
    step();
    stall_i = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall_rd_valid%0d", c), 32'(imem_rd_valid_o), 32'd0);
      check($sformatf("stall_if_valid%0d", c), 32'(if_valid_o), 32'd0);
      check($sformatf("stall_if_pc%0d", c), if_pc_o, 32'h4);
      check($sformatf("stall_instr%0d", c), if_instr_o, word(1));
      step();
    end
    stall_i = 1'b0;
    #1;
    check("unstall_rd_valid", 32'(imem_rd_valid_o), 32'd1);
    check("unstall_addr", 32'(imem_rd_addr_o), 32'd2);
    check("unstall_if_pc", if_pc_o, 32'h4);
    step();
    check("unstall_next_if_valid", 32'(if_valid_o), 32'd1);
    check("unstall_next_if_pc", if_pc_o, 32'h8);
    check("unstall_next_instr", if_instr_o, word(2));
    step();

    // A redirect to 0x40 in the same cycle as a stall: the redirect wins.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    stall_i       = 1'b1;
    #1;
    check("redir_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    check("redir_if_valid", 32'(if_valid_o), 32'd0);
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    #1;
    check("redir_n1_rd_valid", 32'(imem_rd_valid_o), 32'd1);
    check("redir_n1_addr", 32'(imem_rd_addr_o), 32'h10);
    check("redir_n1_if_valid", 32'(if_valid_o), 32'd0);
    step();
    check("redir_n2_if_valid", 32'(if_valid_o), 32'd1);
    check("redir_n2_if_pc", if_pc_o, 32'h40);
    check("redir_n2_instr", if_instr_o, word(16));
    step();

    // Run off the end of the memory: 0x70, 0x74, 0x78, then 0x7C faults.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h70;
    step();
    redirect_i = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("end_rd_valid%0d", c), 32'(imem_rd_valid_o), 32'd1);
      check($sformatf("end_addr%0d", c), 32'(imem_rd_addr_o), 32'(28 + c));
      step();
    end
    check("end_oob_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    check("end_oob_if_valid", 32'(if_valid_o), 32'd1);
    check("end_oob_if_pc", if_pc_o, 32'h78);
    check("end_oob_fault", 32'(fetch_fault_o), 32'd0);
    step();
    for (int c = 0; c < 2; c++) begin
      check($sformatf("halt_fault%0d", c), 32'(fetch_fault_o), 32'd1);
      check($sformatf("halt_rd_valid%0d", c), 32'(imem_rd_valid_o), 32'd0);
      check($sformatf("halt_if_valid%0d", c), 32'(if_valid_o), 32'd0);
      step();
    end
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    #1;
    check("halt_redir_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    step();
    redirect_i = 1'b0;
    #1;
    check("resume_fault", 32'(fetch_fault_o), 32'd0);
    check("resume_rd_valid", 32'(imem_rd_valid_o), 32'd1);
    check("resume_addr", 32'(imem_rd_addr_o), 32'd0);
    step();
    check("resume_if_valid", 32'(if_valid_o), 32'd1);
    check("resume_if_pc", if_pc_o, 32'h0);

    // Misaligned redirect target 0x42.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h42;
    step();
    redirect_i = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_fault", 32'(fetch_fault_o), 32'd1);
    check("misalign_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    step();
    check("misalign_hold_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    check("misalign_hold_fault", 32'(fetch_fault_o), 32'd1);
`else
    check("misalign_fault", 32'(fetch_fault_o), 32'd0);
    check("misalign_rd_valid", 32'(imem_rd_valid_o), 32'd1);
    check("misalign_addr", 32'(imem_rd_addr_o), 32'h10);
    step();
    check("misalign_if_pc", if_pc_o, 32'h40);
    check("misalign_instr", if_instr_o, word(16));
`endif

    // Reset while a request is in flight at pc_q = 0x20.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h18;
    step();
    redirect_i = 1'b0;
    step();
    step();
    reset_i = 1'b1;
    #1;
    check("midrst_pre_if_valid", 32'(if_valid_o), 32'd1);
    check("midrst_pre_if_pc", if_pc_o, 32'h1C);
    check("midrst_rd_valid", 32'(imem_rd_valid_o), 32'd0);
    step();
    reset_i = 1'b0;
    #1;
    check("midrst_if_valid", 32'(if_valid_o), 32'd0);
    check("midrst_fault", 32'(fetch_fault_o), 32'd0);
    check("midrst_rd_valid_after", 32'(imem_rd_valid_o), 32'd1);
    check("midrst_addr", 32'(imem_rd_addr_o), 32'd0);
    step();
    check("midrst_refetch_if_pc", if_pc_o, 32'h0);
    check("midrst_refetch_instr", if_instr_o, word(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter NumEntries, default 31, giving the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter ResetPc, default 32'h0000_0000, giving the byte address of the first fetch.
REQ-003 SHALL define local AddrWidth = $clog2(NumEntries), the memory word-index width.
REQ-004 SHALL have these ports:
- clk_i  in  1  single clock, all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- stall_i  in  1  downstream hold request.
- redirect_i  in  1  branch/jump taken; replace PC.
- redirect_pc_i  in  32  byte address of the redirect target.
- imem_rd_valid_o  out  1  read enable to instruction memory.
- imem_rd_addr_o  out  AddrWidth  word index to instruction memory.
- imem_rd_data_i  in  32  instruction word, valid one cycle after the request.
- if_valid_o  out  1  instruction presented to decode is real.
- if_pc_o  out  32  byte PC of the presented instruction.
- if_instr_o  out  32  presented instruction.
- fetch_fault_o  out  1  fetch halted on a fault.

Function
REQ-005 SHALL hold pc_q (next fetch byte PC), req_pc_q (PC of the in-flight request), inflight_q, and a 2-state FSM {RUN, HALT}.
REQ-006 SHALL drive imem_rd_valid_o = (state==RUN) & !stall_i & !redirect_i & !reset_i & in_range.
REQ-007 SHALL define in_range as (pc_q[AddrWidth+1:2] < NumEntries) & (pc_q[31:AddrWidth+2] == 0).
REQ-008 SHALL drive imem_rd_addr_o = pc_q[AddrWidth+1:2] combinationally.
REQ-009 SHALL, on a cycle where imem_rd_valid_o=1, update pc_q <= pc_q+4 (mod 2^32), req_pc_q <= pc_q, and inflight_q <= 1.
REQ-010 SHALL set if_instr_o = imem_rd_data_i, if_pc_o = req_pc_q, and if_valid_o = inflight_q & !redirect_i & !stall_i; this gives a 1-cycle fetch latency.
REQ-011 SHALL, on stall_i=1 without redirect_i, hold pc_q, req_pc_q and inflight_q; the memory holds its data, so if_instr_o and if_pc_o stay stable.
REQ-012 SHALL, on redirect_i=1, set pc_q <= {redirect_pc_i[31:2],2'b00} and inflight_q <= 0, and issue no request; redirect SHALL take priority over stall_i.
REQ-013 SHALL give a redirect penalty of 2 cycles: redirect in cycle N, target request in N+1, target if_valid_o in N+2.
REQ-014 SHALL, in RUN with in_range=0 and no redirect, go to HALT, set fetch_fault_o=1, clear inflight_q after the current instruction is consumed, and issue no requests.
REQ-015 SHALL, in HALT, leave on redirect_i=1 to RUN with fetch_fault_o cleared and pc_q loaded per REQ-012; stall_i SHALL have no effect in HALT.
REQ-016 SHALL, on a cycle where inflight_q=1, stall_i=0, and no new request is issued, clear inflight_q.

Reset
REQ-017 SHALL, while reset_i=1, force imem_rd_valid_o=0 combinationally.
REQ-018 SHALL, on a clock edge with reset_i=1, load pc_q=ResetPc, req_pc_q=ResetPc, inflight_q=0, state=RUN and fetch_fault_o=0; if_valid_o SHALL then read 0.
REQ-019 SHALL, on reset asserted mid-operation, discard the in-flight request and stall/redirect state; fetch SHALL restart at ResetPc on the first cycle after reset.

Configuration
REQ-020 SHALL support the macro FETCH_MISALIGN_CHECK_EN.
REQ-021 SHALL, when FETCH_MISALIGN_CHECK_EN is defined, treat redirect_i=1 with redirect_pc_i[1:0]!=0 as a fault: go to HALT, set fetch_fault_o=1, and load pc_q as in REQ-012.
REQ-022 SHALL, when FETCH_MISALIGN_CHECK_EN is undefined, silently ignore redirect_pc_i[1:0].

Verification
REQ-023 SHALL cover: reset, then memory words 0..3 preloaded -> imem_rd_addr_o 0,1,2,3 on consecutive cycles; if_valid_o from cycle 2; if_pc_o 0x0,0x4,0x8.
REQ-024 SHALL cover: stall_i high 3 cycles at pc_q=0x8 -> imem_rd_valid_o=0, if_valid_o=0, if_pc_o held at 0x4, if_instr_o stable; on release, next if_pc_o=0x8.
REQ-025 SHALL cover: redirect_i=1 with redirect_pc_i=0x40 together with stall_i=1 -> no request that cycle; address 0x10 requested next cycle; if_valid_o with if_pc_o=0x40 two cycles after the redirect.
REQ-026 SHALL cover: sequential fetch reaching pc_q=0x7C (word 31, NumEntries=31) -> fetch_fault_o=1 and no further imem_rd_valid_o; redirect to 0x0 -> fault clears and fetch resumes.
REQ-027 SHALL cover: redirect_pc_i=0x42 -> with FETCH_MISALIGN_CHECK_EN, HALT and fetch_fault_o=1; without it, the fetch proceeds at 0x40.
REQ-028 SHALL cover: reset_i pulsed while inflight_q=1 at pc_q=0x20 -> if_valid_o=0 next cycle and refetch from ResetPc.
